// File: rtl/vga_char_pkg.sv
// Shared character codes, sizes and state type for the VGA text encoder slice.
package vga_char_pkg;
   localparam int CHAR_W = 6;
   localparam int NCHAR  = 6;
   localparam int BIN_W  = 16;
   localparam int BCD_W  = 20;

   typedef logic [CHAR_W-1:0] char_t;

   localparam char_t CH_SP    = 6'd36;
   localparam char_t CH_MINUS = 6'd37;

   typedef enum logic [1:0] {IDLE, CONV, PACK} enc_state_t;

   function automatic char_t hex2char(input logic [3:0] nib);
      return {2'b00, nib};
   endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit unsigned magnitude to 5 BCD digits, one shift per clock.
module bin2bcd_seq
   import vga_char_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [BCD_W-1:0] bcd
);
   localparam logic [3:0] LAST = 4'(BIN_W - 1);

   logic [BIN_W-1:0] mag;
   logic [3:0]       cnt;
   logic [BCD_W-1:0] bcd_adj;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < BCD_W / 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // done marks the edge that performs the final shift
   assign done = busy && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= '0;
         mag  <= '0;
         bcd  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= '0;
         mag  <= bin;
         bcd  <= '0;
      end else if (busy) begin
         bcd <= {bcd_adj[BCD_W-2:0], mag[BIN_W-1]};
         mag <= {mag[BIN_W-2:0], 1'b0};
         cnt <= cnt + 4'd1;
         if (cnt == LAST) busy <= 1'b0;
      end
   end
endmodule

// File: rtl/vga_text_encoder.sv
// MMIO write to six packed character codes (signed decimal or hex) for the VGA text renderer.
// Optional macro VGA_TEXT_ZERO_BLANK_EN blanks leading decimal zeros and floats the minus sign.
//
// state | meaning
// IDLE  | waiting for a write or a pending job
// CONV  | double-dabble running in bin2bcd_seq
// PACK  | one edge: load vc_data, pulse done
module vga_text_encoder
   import vga_char_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [31:0]             wr_data,
   input  logic                    mode,
   output logic                    busy,
   output logic                    done,
   output logic [NCHAR*CHAR_W-1:0] vc_data
);
   enc_state_t state, state_nx;

   logic                    pend_v, pend_mode;
   logic [4*NCHAR-1:0]      pend_data;
   logic                    job_mode, job_neg;
   logic [4*NCHAR-1:0]      job_data;
   logic                    start_job, sel_mode, conv_start, conv_done;
   logic [4*NCHAR-1:0]      sel_data;
   logic [BIN_W-1:0]        sel_mag;
   logic [BCD_W-1:0]        bcd;
   logic [NCHAR*CHAR_W-1:0] pack_data;
   char_t                   ch [NCHAR];
   logic                    conv_busy_unused;
   logic                    wr_hi_unused;
`ifdef VGA_TEXT_ZERO_BLANK_EN
   logic                    lead;
`endif

   assign wr_hi_unused = ^wr_data[31:24];

   // a fresh write always beats the pending slot
   assign sel_data = wr_en ? wr_data[4*NCHAR-1:0] : pend_data;
   assign sel_mode = wr_en ? mode : pend_mode;
   assign sel_mag  = sel_data[BIN_W-1] ? (~sel_data[BIN_W-1:0] + 16'd1) : sel_data[BIN_W-1:0];

   bin2bcd_seq u_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .bin   (sel_mag),
      .busy  (conv_busy_unused),
      .done  (conv_done),
      .bcd   (bcd)
   );

   always_comb begin
      state_nx   = state;
      start_job  = 1'b0;
      conv_start = 1'b0;
      case (state)
         IDLE: begin
            if (wr_en || pend_v) begin
               start_job = 1'b1;
               if (sel_mode) begin
                  state_nx = PACK;
               end else begin
                  state_nx   = CONV;
                  conv_start = 1'b1;
               end
            end
         end
         CONV:    if (conv_done) state_nx = PACK;
         PACK:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_comb begin
      for (int i = 0; i < NCHAR; i++) ch[i] = hex2char(job_data[4*(NCHAR-1-i) +: 4]);
      if (!job_mode) begin
         ch[0] = job_neg ? CH_MINUS : CH_SP;
         for (int i = 1; i < NCHAR; i++) ch[i] = hex2char(bcd[4*(NCHAR-1-i) +: 4]);
`ifdef VGA_TEXT_ZERO_BLANK_EN
         lead  = 1'b1;
         ch[0] = CH_SP;
         for (int i = 1; i < NCHAR; i++) begin
            if (lead && (i < NCHAR-1) && (bcd[4*(NCHAR-1-i) +: 4] == 4'd0)) begin
               ch[i] = CH_SP;
            end else begin
               if (lead && job_neg) ch[i-1] = CH_MINUS;
               lead = 1'b0;
            end
         end
`endif
      end
      pack_data = '0;
      for (int i = 0; i < NCHAR; i++) pack_data[CHAR_W*(NCHAR-1-i) +: CHAR_W] = ch[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pend_v    <= 1'b0;
         pend_mode <= 1'b0;
         pend_data <= '0;
         job_mode  <= 1'b0;
         job_neg   <= 1'b0;
         job_data  <= '0;
         done      <= 1'b0;
         vc_data   <= {NCHAR{CH_SP}};
      end else begin
         state <= state_nx;
         done  <= 1'b0;
         if (start_job) begin
            job_mode <= sel_mode;
            job_neg  <= ~sel_mode & sel_data[BIN_W-1];
            job_data <= sel_data;
            pend_v   <= 1'b0;
         end else if (wr_en) begin
            pend_v    <= 1'b1;
            pend_data <= wr_data[4*NCHAR-1:0];
            pend_mode <= mode;
         end
         if (state == PACK) begin
            vc_data <= pack_data;
            done    <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_vga_text_encoder.sv
// Scoreboard bench for vga_text_encoder: timeline reference model feeds an expected queue.
module tb_vga_text_encoder;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic        mode = 1'b0;
   logic [31:0] wr_data = '0;
   logic        busy, done;
   logic [35:0] vc_data;

   localparam logic [35:0] ALL_SP = {6{6'd36}};

   vga_text_encoder dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .mode    (mode),
      .busy    (busy),
      .done    (done),
      .vc_data (vc_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [35:0] vc;
      int          at_edge;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          done_edge = -1;
   logic        m_pend_v = 1'b0;
   logic [23:0] m_pend_data = '0;
   logic        m_pend_mode = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_done = 0;

   task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Expected text from the value itself: arithmetic digits, then blanking rules.
   function automatic logic [35:0] ref_text(input logic [23:0] d, input logic hex);
      int          ch[6];
      int          v, m, first;
      bit          neg;
      logic [35:0] r;
      if (hex) begin
         for (int i = 0; i < 6; i++) ch[i] = int'((d >> (20 - 4*i)) & 24'hF);
      end else begin
         v   = int'($signed(d[15:0]));
         neg = (v < 0);
         m   = neg ? -v : v;
         for (int i = 5; i >= 1; i--) begin
            ch[i] = m % 10;
            m     = m / 10;
         end
`ifdef VGA_TEXT_ZERO_BLANK_EN
         first = 5;
         for (int i = 4; i >= 1; i--) if (ch[i] != 0) first = i;
         for (int i = 1; i < first; i++) ch[i] = 36;
         ch[0] = 36;
         if (neg) ch[first-1] = 37;
`else
         first = 0;
         ch[0] = neg ? 37 : 36;
`endif
      end
      r = '0;
      for (int i = 0; i < 6; i++) r = {r[29:0], ch[i][5:0]};
      return r;
   endfunction

   function automatic void model_start(input logic [23:0] d, input logic hex);
      int lat;
      lat = hex ? 1 : 17;
      sb.push_back('{vc: ref_text(d, hex), at_edge: cyc + lat});
      done_edge = cyc + lat;
   endfunction

   // Reference model: a job started at edge c owns the encoder through edge c+latency.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         sb.delete();
         done_edge = -1;
         m_pend_v  = 1'b0;
      end else if (cyc > done_edge) begin
         if (wr_en) begin
            model_start(wr_data[23:0], mode);
            m_pend_v = 1'b0;
         end else if (m_pend_v) begin
            model_start(m_pend_data, m_pend_mode);
            m_pend_v = 1'b0;
         end
      end else if (wr_en) begin
         m_pend_v    = 1'b1;
         m_pend_data = wr_data[23:0];
         m_pend_mode = mode;
      end
   end

   // Monitor: pops the scoreboard on every done pulse, otherwise demands a stable vc_data.
   initial begin
      logic [35:0] prev_vc;
      exp_t        e;
      prev_vc = ALL_SP;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            chk("reset_vc_data", vc_data, ALL_SP);
            chk("reset_busy", 36'(busy), 36'd0);
            chk("reset_done", 36'(done), 36'd0);
         end else begin
            chk("busy", 36'(busy), 36'(cyc < done_edge));
            if (done) begin
               n_done++;
               if (sb.size() == 0) begin
                  chk("unexpected_done", 36'(done), 36'd0);
               end else begin
                  e = sb.pop_front();
                  chk("vc_data", vc_data, e.vc);
                  chk("done_edge", 36'(cyc), 36'(e.at_edge));
               end
            end else begin
               if (sb.size() > 0 && sb[0].at_edge <= cyc) begin
                  e = sb.pop_front();
                  chk("missing_done", 36'(done), 36'd1);
               end
               chk("vc_hold", vc_data, prev_vc);
            end
         end
         prev_vc = vc_data;
      end
   end

   task automatic wr(input logic [31:0] d, input logic m);
      wr_en   = 1'b1;
      wr_data = d;
      mode    = m;
      @(negedge clk);
      wr_en   = 1'b0;
      wr_data = $urandom;
      mode    = 1'($urandom_range(1));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int          nd0, w;
      logic [31:0] corner [10];
      corner = '{32'd0, 32'd1, 32'd9, 32'd10, 32'hFFFF, 32'd32767, 32'h8000,
                 32'hD8F0, 32'd1000, 32'hFFF6};
      #2 rst = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(2);
      chk("after_reset_vc", vc_data, ALL_SP);

      wr(32'd12345, 1'b0);
      idle(20);
      wr(32'h0000_8000, 1'b0);
      idle(20);
      wr(32'h0000_FFF9, 1'b0);
      idle(20);
      wr(32'hFFAB_C123, 1'b1);
      idle(3);

      // overwrite of the pending slot: 100 shown, 200 dropped, 300 shown
      nd0 = n_done;
      wr(32'd100, 1'b0);
      idle(2);
      wr(32'd200, 1'b0);
      idle(1);
      wr(32'd300, 1'b0);
      idle(45);
      chk("two_done_pulses", 36'(n_done - nd0), 36'd2);

      // write landing on the PACK edge is queued, then runs
      nd0 = n_done;
      wr(32'd4321, 1'b0);
      idle(16);
      wr(32'h0012_3456, 1'b1);
      idle(6);
      chk("pack_edge_queued", 36'(n_done - nd0), 36'd2);

      // reset mid-conversion with a pending job: nothing may complete afterwards
      wr(32'd777, 1'b0);
      idle(2);
      wr(32'd888, 1'b0);
      idle(3);
      nd0 = n_done;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(40);
      chk("no_done_after_reset", 36'(n_done - nd0), 36'd0);
      chk("vc_spaces_after_reset", vc_data, ALL_SP);

      foreach (corner[i]) begin
         wr(corner[i], 1'b0);
         idle(int'($urandom_range(25)));
      end

      repeat (500) begin
         if ($urandom_range(7) == 0) wr($urandom, 1'($urandom_range(1)));
         else idle(1);
      end

      w = 0;
      while ((sb.size() > 0 || m_pend_v) && w < 200) begin
         idle(1);
         w++;
      end
      chk("drain_timeout", 36'(sb.size()), 36'd0);
      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
